fetch_unit: RTL

Instruction fetch stage of the RV32I single-cycle core, directly upstream of the immediate generator. Holds the program counter and fetches one instruction at a time from instruction memory over a request/grant/valid handshake. Presents the fetched word on `instr`, which feeds the immediate generator and decoder. Computes the next PC from the immediates and control decisions it receives back at retirement.

---
 rtl/fetch_unit.sv | 132 +++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit -- RV32I instruction fetch stage.
//
// Holds the PC and fetches one instruction at a time over a
// req/gnt/rvalid handshake. The fetched word is held on instr until the
// downstream retires it. The next PC is then computed from the retire-cycle
// control inputs and immediates.
//
// Build option: FETCH_MISALIGN_TRAP_EN
//   defined   : a misaligned next PC (target bit 1 set) redirects to
//               TRAP_VEC and misalign pulses for one cycle.
//   undefined : the next PC is loaded with bits [1:0] cleared and
//               misalign is tied low.
//
// Ports
//   clk, rst                 clock, async active-high reset
//   imem_req/addr            fetch request and address (addr == pc)
//   imem_gnt                 request accepted
//   imem_rvalid/rdata        fetched word return
//   stall                    downstream holds the current instruction
//   branch_taken, jal, jalr  retire-cycle redirect controls
//   rs1_data                 JALR base
//   i_imme, sb_imme, uj_imme sign-extended immediates
//   instr, instr_valid       current instruction word and its valid flag
//   pc, pc_plus4             address of instr and its link value
//   misalign                 one-cycle pulse on a misaligned redirect
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic        jal,
    input  logic        jalr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] i_imme,
    input  logic [31:0] sb_imme,
    input  logic [31:0] uj_imme,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        misalign
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] target;
    logic [31:0] next_pc;
    logic        trap_hit;

    // Redirect target, priority jalr > jal > branch > sequential.
    always_comb begin
        target = pc_q + 32'd4;
        if (jalr)              target = (rs1_data + i_imme) & ~32'h1;
        else if (jal)          target = pc_q + uj_imme;
        else if (branch_taken) target = pc_q + sb_imme;
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    assign trap_hit = target[1];
    assign next_pc  = trap_hit ? TRAP_VEC : target;
`else
    logic unused_cfg;
    assign trap_hit   = 1'b0;
    assign next_pc    = {target[31:2], 2'b00};
    assign unused_cfg = ^{TRAP_VEC, target[1:0]};
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ:  if (imem_gnt) state_d = S_WAIT;
            S_WAIT: if (imem_rvalid) begin
                instr_d = imem_rdata;
                state_d = S_HOLD;
            end
            S_HOLD: if (!stall) begin
                pc_d    = next_pc;
                state_d = S_REQ;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= NOP;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;
    // Set only by the retire edge, so it self-clears one cycle later.
    assign misalign_d = (state_q == S_HOLD) && !stall && trap_hit;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) misalign_q <= 1'b0;
        else     misalign_q <= misalign_d;
    end
    assign misalign = misalign_q;
`else
    assign misalign = 1'b0;
`endif

    assign imem_req    = (state_q == S_REQ);
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = (state_q == S_HOLD);
    assign pc          = pc_q;
    assign pc_plus4    = pc_q + 32'd4;

endmodule
